// File: rtl/game_frame_scanner_pkg.sv
// rtl/game_frame_scanner_pkg.sv - shared screen geometry and colour defaults for the game display path
package DinoGameConstants;

  localparam int unsigned SCREEN_COORD_W  = 8;
  localparam int unsigned SCREEN_X_MAX    = 159;
  localparam int unsigned SCREEN_Y_MAX    = 119;
  localparam int unsigned SCREEN_COLOR_W  = 3;
  localparam int unsigned SCREEN_BG_COLOR = 0;

endpackage

// File: rtl/game_frame_scanner_scan_pipe.sv
// rtl/game_frame_scanner_scan_pipe.sv - stallable valid/x/y delay line matching the colour-source latency
module game_scan_pipe
  import DinoGameConstants::*;
#(
  parameter int unsigned COORD_W = SCREEN_COORD_W,
  parameter int unsigned LAT     = 1
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_valid,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_tail_valid,
  output logic               o_inflight
);

  localparam int L = int'(LAT);

  logic [L-1:0]              r_v;
  logic [L-1:0][COORD_W-1:0] r_x;
  logic [L-1:0][COORD_W-1:0] r_y;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_v <= '0;
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      r_v[0] <= i_valid;
      r_x[0] <= i_x;
      r_y[0] <= i_y;
      for (int i = 1; i < L; i++) begin
        r_v[i] <= r_v[i-1];
        r_x[i] <= r_x[i-1];
        r_y[i] <= r_y[i-1];
      end
    end
  end

  assign o_valid = r_v[L-1];
  assign o_x     = r_x[L-1];
  assign o_y     = r_y[L-1];

  // The tail valid is what will land in the output stage on the next advance.
  generate
    if (L == 1) begin : g_lat1
      assign o_tail_valid = i_valid;
      assign o_inflight   = 1'b0;
    end else begin : g_latn
      assign o_tail_valid = r_v[L-2];
      assign o_inflight   = |r_v[L-2:0];
    end
  endgenerate

endmodule

// File: rtl/game_frame_scanner.sv
// rtl/game_frame_scanner.sv - raster scanner: walks a frame/window, fetches colours, plots pixels with backpressure
module game_frame_scanner
  import DinoGameConstants::*;
#(
  parameter int unsigned COORD_W  = SCREEN_COORD_W,
  parameter int unsigned X_MAX    = SCREEN_X_MAX,
  parameter int unsigned Y_MAX    = SCREEN_Y_MAX,
  parameter int unsigned COLOR_W  = SCREEN_COLOR_W,
  parameter int unsigned LAT      = 1,
  parameter int unsigned BG_COLOR = SCREEN_BG_COLOR
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               frame_clk,
  input  logic               win_mode,
  input  logic [COORD_W-1:0] win_x0,
  input  logic [COORD_W-1:0] win_y0,
  input  logic [COORD_W-1:0] win_x1,
  input  logic [COORD_W-1:0] win_y1,
  output logic [COORD_W-1:0] src_x,
  output logic [COORD_W-1:0] src_y,
  input  logic [COLOR_W-1:0] src_color,
  output logic               src_advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] color,
  output logic               plot_pixel,
  input  logic               plot_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [COORD_W-1:0] LP_X_MAX = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] LP_Y_MAX = COORD_W'(Y_MAX);
  localparam logic [COLOR_W-1:0] LP_BG    = COLOR_W'(BG_COLOR);

  logic [1:0]         r_state;
  logic [COORD_W-1:0] r_cx, r_cy, r_x0, r_x1, r_y1;
  logic [COLOR_W-1:0] r_color;
  logic               r_frame_done, r_overrun;

  logic               w_adv, w_busy, w_start, w_empty, w_drain_done;
  logic [COORD_W-1:0] w_x1c, w_y1c, w_bx0, w_bx1, w_by0, w_by1;
  logic               w_pipe_valid, w_tail_valid, w_inflight;
  logic [COORD_W-1:0] w_pipe_x, w_pipe_y;

  assign w_adv  = enable && (plot_ready || !w_pipe_valid);
  assign w_busy = (r_state != ST_IDLE);

  assign w_x1c = (win_x1 > LP_X_MAX) ? LP_X_MAX : win_x1;
  assign w_y1c = (win_y1 > LP_Y_MAX) ? LP_Y_MAX : win_y1;
  assign w_bx0 = win_mode ? win_x0 : '0;
  assign w_by0 = win_mode ? win_y0 : '0;
  assign w_bx1 = win_mode ? w_x1c  : LP_X_MAX;
  assign w_by1 = win_mode ? w_y1c  : LP_Y_MAX;
  assign w_empty = (w_bx0 > w_bx1) || (w_by0 > w_by1);

  // A request landing in the frame_done cycle counts as an overrun, not a start.
  assign w_start      = (r_state == ST_IDLE) && w_adv && frame_clk && !r_frame_done;
  assign w_drain_done = (r_state == ST_DRAIN) && w_adv && !w_inflight;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else if (w_adv) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start && !w_empty) begin
            r_state <= ST_SCAN;
            r_cx    <= w_bx0;
            r_cy    <= w_by0;
            r_x0    <= w_bx0;
            r_x1    <= w_bx1;
            r_y1    <= w_by1;
          end
        end
        ST_SCAN: begin
          if (r_cx == r_x1) begin
            if (r_cy == r_y1) begin
              r_state <= ST_DRAIN;
            end else begin
              r_cx <= r_x0;
              r_cy <= r_cy + COORD_W'(1);
            end
          end else begin
            r_cx <= r_cx + COORD_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!w_inflight) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Event pulses refresh every cycle so they stay one cycle wide even when stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= (w_start && w_empty) || w_drain_done;
      r_overrun    <= enable && frame_clk && (w_busy || r_frame_done);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_color <= LP_BG;
    end else if (w_adv) begin
      r_color <= w_tail_valid ? src_color : LP_BG;
    end
  end

  game_scan_pipe #(
    .COORD_W (COORD_W),
    .LAT     (LAT)
  ) u_pipe (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .i_en         (w_adv),
    .i_valid      (r_state == ST_SCAN),
    .i_x          (r_cx),
    .i_y          (r_cy),
    .o_valid      (w_pipe_valid),
    .o_x          (w_pipe_x),
    .o_y          (w_pipe_y),
    .o_tail_valid (w_tail_valid),
    .o_inflight   (w_inflight)
  );

  assign src_x       = (r_state == ST_SCAN) ? r_cx : '0;
  assign src_y       = (r_state == ST_SCAN) ? r_cy : '0;
  assign src_advance = w_adv;
  assign x           = w_pipe_x;
  assign y           = w_pipe_y;
  assign color       = r_color;
  assign plot_pixel  = w_pipe_valid;
  assign busy        = w_busy;
  assign frame_done  = r_frame_done;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_game_frame_scanner.sv
// tb/tb_game_frame_scanner.sv - table-driven scoreboard bench for game_frame_scanner (X_MAX=3, Y_MAX=2, LAT=2)
module tb_game_frame_scanner;

  localparam int CW   = 8;
  localparam int XM   = 3;
  localparam int YM   = 2;
  localparam int COLW = 3;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            resetn, enable, frame_clk, win_mode, plot_ready;
  logic [CW-1:0]   win_x0, win_y0, win_x1, win_y1;
  logic [CW-1:0]   src_x, src_y, x, y;
  logic [COLW-1:0] src_color, color;
  logic            src_advance, plot_pixel, busy, frame_done, overrun;
  logic [CW-1:0]   sq_x, sq_y;

  always #5 clk = ~clk;

  game_frame_scanner #(
    .COORD_W (CW), .X_MAX (XM), .Y_MAX (YM), .COLOR_W (COLW), .LAT (LAT), .BG_COLOR (0)
  ) dut (
    .clk (clk), .resetn (resetn), .enable (enable), .frame_clk (frame_clk),
    .win_mode (win_mode), .win_x0 (win_x0), .win_y0 (win_y0), .win_x1 (win_x1), .win_y1 (win_y1),
    .src_x (src_x), .src_y (src_y), .src_color (src_color), .src_advance (src_advance),
    .x (x), .y (y), .color (color), .plot_pixel (plot_pixel), .plot_ready (plot_ready),
    .busy (busy), .frame_done (frame_done), .overrun (overrun)
  );

  function automatic logic [COLW-1:0] pix_color(input logic [CW-1:0] px, input logic [CW-1:0] py);
    return COLW'((32'(px) * 3 + 32'(py) * 5 + 1) % 8);
  endfunction

  // Colour source with LAT-1 registers advancing on src_advance.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sq_x <= '0;
      sq_y <= '0;
    end else if (src_advance) begin
      sq_x <= src_x;
      sq_y <= src_y;
    end
  end
  assign src_color = pix_color(sq_x, sq_y);

  typedef struct packed {
    logic [CW-1:0]   px;
    logic [CW-1:0]   py;
    logic [COLW-1:0] pc;
  } pix_t;

  typedef struct {
    logic mode;
    int   x0, y0, x1, y1;
    int   ex0, ex1, ey0, ey1;
    int   n;
  } frame_vec_t;

  frame_vec_t vecs[8];
  pix_t       exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_xfer = 0, n_done = 0, n_ovr = 0, n_stall = 0, n_rise = 0;
  int rise_cyc = 0, first_pix_cyc = 0, last_xfer_cyc = 0, done_cyc = 0, clk_cyc = 0;
  int busy_run = 0, busy_len_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic            prev_busy = 1'b0, prev_stall = 1'b0, prev_done = 1'b0, seen_pix = 1'b0;
    logic [CW-1:0]   hx = '0, hy = '0;
    logic [COLW-1:0] hc = '0;
    pix_t            e;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("hold_valid", int'(plot_pixel), 1);
        chk("hold_x", int'(x), int'(hx));
        chk("hold_y", int'(y), int'(hy));
        chk("hold_color", int'(color), int'(hc));
      end
      if (busy && !prev_busy) begin
        rise_cyc = cyc;
        seen_pix = 1'b0;
        n_rise++;
      end
      if (busy) busy_run++;
      else begin
        if (prev_busy) busy_len_last = busy_run;
        busy_run = 0;
      end
      if (plot_pixel && !seen_pix) begin
        first_pix_cyc = cyc;
        seen_pix = 1'b1;
      end
      if (plot_pixel && !plot_ready) n_stall++;
      if (plot_pixel && plot_ready) begin
        n_xfer++;
        last_xfer_cyc = cyc;
        chk("sb_has_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pix_x", int'(x), int'(e.px));
          chk("pix_y", int'(y), int'(e.py));
          chk("pix_color", int'(color), int'(e.pc));
        end
      end
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
        chk("done_one_cycle", int'(prev_done), 0);
      end
      if (overrun) n_ovr++;
      if (frame_clk && enable && !busy && !frame_done) clk_cyc = cyc;
      prev_stall = plot_pixel && !plot_ready;
      prev_done  = frame_done;
      prev_busy  = busy;
      hx = x;
      hy = y;
      hc = color;
    end
  endtask

  task automatic push_frame(input frame_vec_t v);
    pix_t e;
    for (int yy = v.ey0; yy <= v.ey1; yy++) begin
      for (int xx = v.ex0; xx <= v.ex1; xx++) begin
        e.px = CW'(xx);
        e.py = CW'(yy);
        e.pc = pix_color(CW'(xx), CW'(yy));
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_frame_clk();
    @(posedge clk); #1 frame_clk = 1'b1;
    @(posedge clk); #1 frame_clk = 1'b0;
  endtask

  task automatic wait_done(input string name, input int done0);
    int k = 0;
    while (n_done == done0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_done_seen"}, int'(n_done > done0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_win(input frame_vec_t v);
    win_mode = v.mode;
    win_x0 = CW'(v.x0);
    win_y0 = CW'(v.y0);
    win_x1 = CW'(v.x1);
    win_y1 = CW'(v.y1);
  endtask

  task automatic run_vec(input string name, input frame_vec_t v);
    int x0 = n_xfer, d0 = n_done, r0 = n_rise;
    set_win(v);
    push_frame(v);
    pulse_frame_clk();
    wait_done(name, d0);
    chk({name, "_xfer_count"}, n_xfer - x0, v.n);
    chk({name, "_sb_drained"}, exp_q.size(), 0);
    chk({name, "_done_count"}, n_done - d0, 1);
    chk({name, "_busy_after"}, int'(busy), 0);
    if (v.n > 0) begin
      chk({name, "_start_latency"}, rise_cyc - clk_cyc, 1);
      chk({name, "_first_pix_latency"}, first_pix_cyc - rise_cyc, LAT);
      chk({name, "_back_to_back"}, last_xfer_cyc - first_pix_cyc, v.n - 1);
      chk({name, "_busy_len"}, busy_len_last, v.n + LAT);
    end else begin
      chk({name, "_empty_done_latency"}, done_cyc - clk_cyc, 1);
      chk({name, "_empty_no_busy"}, n_rise - r0, 0);
    end
  endtask

  initial begin
    int   x0, d0, o0, r0, s0, k;
    logic found;
    frame_vec_t full, one;

    resetn = 1'b1; enable = 1'b1; frame_clk = 1'b0; plot_ready = 1'b1;
    win_mode = 1'b0; win_x0 = '0; win_y0 = '0; win_x1 = '0; win_y1 = '0;

    //          mode  x0 y0 x1 y1  ex0 ex1 ey0 ey1  n
    vecs[0] = '{1'b0, 2, 2, 1, 1,  0,  3,  0,  2,  12};
    vecs[1] = '{1'b1, 1, 1, 9, 1,  1,  3,  1,  1,  3};
    vecs[2] = '{1'b1, 0, 2, 3, 9,  0,  3,  2,  2,  4};
    vecs[3] = '{1'b1, 2, 0, 2, 2,  2,  2,  0,  2,  3};
    vecs[4] = '{1'b1, 3, 0, 1, 2,  1,  0,  0,  0,  0};
    vecs[5] = '{1'b1, 0, 2, 3, 1,  1,  0,  0,  0,  0};
    vecs[6] = '{1'b1, 3, 2, 3, 2,  3,  3,  2,  2,  1};
    vecs[7] = '{1'b1, 5, 0, 9, 0,  1,  0,  0,  0,  0};
    full = vecs[0];
    one  = vecs[6];

    fork
      monitor();
    join_none

    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_src_x", int'(src_x), 0);
    chk("rst_src_y", int'(src_y), 0);
    chk("rst_color", int'(color), 0);
    chk("rst_plot_pixel", int'(plot_pixel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1 resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure on pixel (2,0) for three cycles.
    x0 = n_xfer; d0 = n_done; s0 = n_stall;
    set_win(full);
    push_frame(full);
    pulse_frame_clk();
    found = 1'b0;
    k = 0;
    while (!found && k < 50) begin
      @(negedge clk);
      found = plot_pixel && (x == 8'd1) && (y == 8'd0);
      k++;
    end
    chk("bp_found_1_0", int'(found), 1);
    @(posedge clk); #1 plot_ready = 1'b0;
    chk("bp_pending_x", int'(x), 2);
    chk("bp_pending_y", int'(y), 0);
    repeat (3) @(posedge clk);
    #1 plot_ready = 1'b1;
    wait_done("bp", d0);
    chk("bp_stall_cycles", n_stall - s0, 3);
    chk("bp_xfer_count", n_xfer - x0, 12);
    chk("bp_sb_drained", exp_q.size(), 0);
    chk("bp_span", last_xfer_cyc - first_pix_cyc, 11 + 3);

    // frame_clk and window changes mid-scan must not disturb the frame.
    x0 = n_xfer; d0 = n_done; o0 = n_ovr;
    set_win(full);
    push_frame(full);
    pulse_frame_clk();
    repeat (3) @(posedge clk);
    #1;
    win_mode = 1'b1; win_x0 = 8'd1; win_y0 = 8'd1; win_x1 = 8'd2; win_y1 = 8'd1;
    pulse_frame_clk();
    wait_done("ovr", d0);
    chk("ovr_count", n_ovr - o0, 1);
    chk("ovr_xfer_count", n_xfer - x0, 12);
    chk("ovr_sb_drained", exp_q.size(), 0);

    // frame_clk in the frame_done cycle is an overrun, not a new frame.
    x0 = n_xfer; o0 = n_ovr; r0 = n_rise;
    set_win(one);
    push_frame(one);
    pulse_frame_clk();
    k = 0;
    while (!frame_done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("fdclk_done_seen", int'(frame_done), 1);
    frame_clk = 1'b1;
    @(posedge clk); #1 frame_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("fdclk_overrun", n_ovr - o0, 1);
    chk("fdclk_no_restart", n_rise - r0, 1);
    chk("fdclk_xfer_count", n_xfer - x0, 1);
    chk("fdclk_sb_drained", exp_q.size(), 0);

    // Asynchronous reset mid-frame, then a clean full frame.
    set_win(full);
    push_frame(full);
    pulse_frame_clk();
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_plot_pixel", int'(plot_pixel), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_x", int'(x), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_src_x", int'(src_x), 0);
    chk("midrst_src_y", int'(src_y), 0);
    chk("midrst_color", int'(color), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    @(posedge clk); #1 resetn = 1'b1;
    run_vec("after_rst", full);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
